pipe_stage_reg: RTL and testbench

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

---
 rtl/pipe_pkg.sv | 21 ++
 rtl/pipe_skid_buf.sv | 72 +++++++
 rtl/pipe_stage_reg.sv | 172 +++++++++++++++++
 tb/tb_pipe_stage_reg.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// ---------------------------------------------------------------------------
// pipe_pkg
// Types and constants shared by the pipeline stage register and its skid
// storage.
//   stage_state_e : occupancy state of a stage
//                   (EMPTY/FULL for the 1-entry build, EMPTY/ONE/TWO for the
//                   2-entry build)
//   PIPE_BUBBLE   : payload presented while a stage holds nothing
// ---------------------------------------------------------------------------
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2,
        FULL  = 2'd3
    } stage_state_e;

    localparam logic [31:0] PIPE_BUBBLE = 32'hfedcba98;

endpackage : pipe_pkg

// File: rtl/pipe_skid_buf.sv
// ---------------------------------------------------------------------------
// pipe_skid_buf
// Two-entry FIFO storage for the skid variant of pipe_stage_reg.
// It holds the data only. The parent stage tracks occupancy and never writes
// when the buffer is full or reads when it is empty.
// Ports:
//   clk, rst  : clock and asynchronous active-high reset
//   clear     : synchronous discard; both selects return to entry 0
//   wr_en     : store wr_data in the entry the write select points to
//   wr_data   : payload to store (WIDTH bits)
//   rd_en     : retire the entry the read select points to
//   rd_data   : oldest held entry (WIDTH bits)
// ---------------------------------------------------------------------------
module pipe_skid_buf #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] entry0_q, entry0_d;
    logic [WIDTH-1:0] entry1_q, entry1_d;
    logic             wr_sel_q, wr_sel_d;
    logic             rd_sel_q, rd_sel_d;

    // Each select toggles when its side moves. Because of this, a write and a
    // read in the same cycle keep the order of the entries intact.
    always_comb begin
        entry0_d = entry0_q;
        entry1_d = entry1_q;
        wr_sel_d = wr_sel_q;
        rd_sel_d = rd_sel_q;
        if (clear) begin
            wr_sel_d = 1'b0;
            rd_sel_d = 1'b0;
        end else begin
            if (wr_en) begin
                if (wr_sel_q) begin
                    entry1_d = wr_data;
                end else begin
                    entry0_d = wr_data;
                end
                wr_sel_d = ~wr_sel_q;
            end
            if (rd_en) begin
                rd_sel_d = ~rd_sel_q;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            entry0_q <= '0;
            entry1_q <= '0;
            wr_sel_q <= 1'b0;
            rd_sel_q <= 1'b0;
        end else begin
            entry0_q <= entry0_d;
            entry1_q <= entry1_d;
            wr_sel_q <= wr_sel_d;
            rd_sel_q <= rd_sel_d;
        end
    end

    assign rd_data = rd_sel_q ? entry1_q : entry0_q;

endmodule : pipe_skid_buf

// File: rtl/pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// pipe_stage_reg
// Valid/ready pipeline stage register with a latency of one cycle. It also
// counts the cycles in which the stage is stalled.
// Build option:
//   PIPE_STAGE_SKID_EN defined   -> 2-entry skid stage. in_ready is
//                                   registered and has no combinational path
//                                   from out_ready.
//   PIPE_STAGE_SKID_EN undefined -> 1-entry stage.
//                                   in_ready = !out_valid || out_ready.
// Parameters: WIDTH (payload bits), BUBBLE (idle payload, cut to WIDTH bits),
//             CNT_W (stall counter width)
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   flush               : synchronous clear of held entries; drops any push
//                         in the same cycle
//   in_valid/in_ready   : upstream handshake
//   in_data             : upstream payload
//   out_valid/out_ready : downstream handshake
//   out_data            : presented payload (BUBBLE when out_valid is 0)
//   stall_cnt           : saturating count of cycles with
//                         out_valid && !out_ready
// ---------------------------------------------------------------------------
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int             WIDTH  = 32,
    parameter logic [255:0]   BUBBLE = 256'(PIPE_BUBBLE),
    parameter int             CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [WIDTH-1:0] BUBBLE_W = BUBBLE[WIDTH-1:0];
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    stage_state_e     state_q, state_d;
    logic             push;
    logic             pop;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    assign out_valid = (state_q != EMPTY);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // The stall counter saturates and ignores flush. Only reset clears it.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (out_valid && !out_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;

`ifdef PIPE_STAGE_SKID_EN

    logic             in_ready_q, in_ready_d;
    logic [WIDTH-1:0] head_data;

    // Occupancy tracking for the two-entry buffer. Flush has priority over
    // both push and pop. In TWO no push can occur, because in_ready is low.
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: if (push) state_d = ONE;
                ONE: begin
                    if (push && !pop) begin
                        state_d = TWO;
                    end else if (!push && pop) begin
                        state_d = EMPTY;
                    end
                end
                TWO: if (pop) state_d = ONE;
                default: state_d = EMPTY;
            endcase
        end
        in_ready_d = (state_d != TWO);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
        end
    end

    pipe_skid_buf #(
        .WIDTH (WIDTH)
    ) u_skid_buf (
        .clk     (clk),
        .rst     (rst),
        .clear   (flush),
        .wr_en   (push && !flush),
        .wr_data (in_data),
        .rd_en   (pop && !flush),
        .rd_data (head_data)
    );

    assign in_ready = in_ready_q;
    assign out_data = out_valid ? head_data : BUBBLE_W;

`else

    logic [WIDTH-1:0] data_q, data_d;

    // One entry. In FULL a push can only happen together with a pop, because
    // in_ready then depends on out_ready. The new data replaces the old.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (push) begin
                        state_d = FULL;
                        data_d  = in_data;
                    end
                end
                FULL: begin
                    if (push) begin
                        data_d = in_data;
                    end else if (pop) begin
                        state_d = EMPTY;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
            data_q  <= BUBBLE_W;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
        end
    end

    assign in_ready = !out_valid || out_ready;
    assign out_data = out_valid ? data_q : BUBBLE_W;

`endif

endmodule : pipe_stage_reg

// File: tb/tb_pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// tb_pipe_stage_reg
// Testbench for pipe_stage_reg. It drives two instances with the same
// inputs:
//   dut       : default parameters (WIDTH=32, CNT_W=16)
//   dut_small : WIDTH=8 (bubble cut to 8'h98) and CNT_W=4, used for the
//               saturation behaviour
// A queue-based reference model gives all expected values. It follows the
// build option PIPE_STAGE_SKID_EN.
// ---------------------------------------------------------------------------
module tb_pipe_stage_reg;

    localparam logic [31:0] BUB32 = 32'hfedcba98;
    localparam logic [31:0] BUB8  = 32'h00000098;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_data;
    logic        out_ready;

    logic        in_ready_a, out_valid_a;
    logic [31:0] out_data_a;
    logic [15:0] stall_cnt_a;
    logic        in_ready_b, out_valid_b;
    logic [7:0]  out_data_b;
    logic [3:0]  stall_cnt_b;

    int testCount = 0;
    int failCount = 0;

    // Reference model state
    logic [31:0] modelQ[$];
    int          modelStall;
    int          modelStallSmall;
    logic        expReady;

    always #5 clk = ~clk;

    pipe_stage_reg dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready_a),
        .in_data   (in_data),
        .out_valid (out_valid_a),
        .out_ready (out_ready),
        .out_data  (out_data_a),
        .stall_cnt (stall_cnt_a)
    );

    pipe_stage_reg #(
        .WIDTH (8),
        .CNT_W (4)
    ) dut_small (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready_b),
        .in_data   (in_data[7:0]),
        .out_valid (out_valid_b),
        .out_ready (out_ready),
        .out_data  (out_data_b),
        .stall_cnt (stall_cnt_b)
    );

    // Compares one observed value with the expected value.
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // The stage takes data when it has room. The 1-entry build also takes
    // data when the held entry leaves in the same cycle.
    function automatic logic modelReady(input logic ordy);
`ifdef PIPE_STAGE_SKID_EN
        return (modelQ.size() < 2);
`else
        return (modelQ.size() == 0) || ordy;
`endif
    endfunction

    task automatic modelReset();
        modelQ.delete();
        modelStall      = 0;
        modelStallSmall = 0;
    endtask

    // Checks the registered outputs of both instances against the model.
    task automatic checkOutput(input string tag);
        logic [31:0] expData;
        logic        expValid;
        expValid = (modelQ.size() != 0);
        expData  = expValid ? modelQ[0] : BUB32;
        check({tag, ".valid"},    {31'd0, out_valid_a}, {31'd0, expValid});
        check({tag, ".data"},     out_data_a, expData);
        check({tag, ".stall"},    {16'd0, stall_cnt_a}, modelStall);
        check({tag, ".valid8"},   {31'd0, out_valid_b}, {31'd0, expValid});
        check({tag, ".data8"},    {24'd0, out_data_b}, expValid ? {24'd0, expData[7:0]} : BUB8);
        check({tag, ".stall4"},   {28'd0, stall_cnt_b}, modelStallSmall);
    endtask

    // Runs one clock cycle with the given inputs. It checks in_ready before
    // the edge, updates the model at the edge, then checks the outputs.
    task automatic applyStimulus(input string tag, input logic iv, input logic [31:0] id,
                                 input logic ordy, input logic fl);
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
        flush     = fl;
        #1;
        expReady = modelReady(ordy);
        check({tag, ".in_ready"},  {31'd0, in_ready_a}, {31'd0, expReady});
        check({tag, ".in_ready8"}, {31'd0, in_ready_b}, {31'd0, expReady});
        @(posedge clk);
        if ((modelQ.size() != 0) && !ordy) begin
            modelStall      = (modelStall < 65535) ? modelStall + 1 : 65535;
            modelStallSmall = (modelStallSmall < 15) ? modelStallSmall + 1 : 15;
        end
        if (fl) begin
            modelQ.delete();
        end else begin
            if ((modelQ.size() != 0) && ordy) void'(modelQ.pop_front());
            if (iv && expReady) modelQ.push_back(id);
        end
        @(negedge clk);
        checkOutput(tag);
    endtask

    // Raises reset between clock edges and checks that its effect is
    // immediate. Reset then stays high across one edge.
    task automatic midCycleReset(input string tag);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        flush     = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check({tag, ".valid"},    {31'd0, out_valid_a}, 32'd0);
        check({tag, ".data"},     out_data_a, BUB32);
        check({tag, ".stall"},    {16'd0, stall_cnt_a}, 32'd0);
        check({tag, ".in_ready"}, {31'd0, in_ready_a}, 32'd1);
        check({tag, ".data8"},    {24'd0, out_data_b}, BUB8);
        check({tag, ".stall4"},   {28'd0, stall_cnt_b}, 32'd0);
        modelReset();
        @(negedge clk);
        rst = 1'b0;
        #1;
        check({tag, ".in_ready_after"}, {31'd0, in_ready_a}, 32'd1);
    endtask

    initial begin
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        modelReset();
        #2;
        checkOutput("reset");
        check("reset.in_ready", {31'd0, in_ready_a}, 32'd1);
        @(negedge clk);
        rst = 1'b0;

        // Streaming: 1..10 with no backpressure, then drain
        for (int i = 1; i <= 10; i++) applyStimulus("stream", 1'b1, i, 1'b1, 1'b0);
        applyStimulus("stream_drain", 1'b0, 32'd0, 1'b1, 1'b0);

        // Stall: push 0xA, then 5 stalled cycles. The first of them offers 0xB.
        applyStimulus("stall_push", 1'b1, 32'hA, 1'b0, 1'b0);
        applyStimulus("stall1", 1'b1, 32'hB, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) applyStimulus("stall", 1'b0, 32'd0, 1'b0, 1'b0);
        check("stall.count5", {16'd0, stall_cnt_a}, 32'd5);

        // Drain in order
        for (int i = 0; i < 3; i++) applyStimulus("drain", 1'b0, 32'd0, 1'b1, 1'b0);

        // Flush while holding data, with a push of 0xC in the same cycle
        applyStimulus("flush_pre", 1'b1, 32'hD, 1'b0, 1'b0);
        applyStimulus("flush", 1'b1, 32'hC, 1'b0, 1'b1);
        check("flush.bubble", out_data_a, BUB32);
        for (int i = 0; i < 3; i++) applyStimulus("flush_post", 1'b0, 32'd0, 1'b1, 1'b0);

        // Saturation of the 4-bit counter, held across a flush
        applyStimulus("sat_push", 1'b1, 32'h5A, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) applyStimulus("sat", 1'b0, 32'd0, 1'b0, 1'b0);
        check("sat.full", {28'd0, stall_cnt_b}, 32'hF);
        applyStimulus("sat_flush", 1'b0, 32'd0, 1'b0, 1'b1);
        applyStimulus("sat_hold", 1'b0, 32'd0, 1'b1, 1'b0);
        check("sat.hold", {28'd0, stall_cnt_b}, 32'hF);

        // Reset in the middle of a transfer, then a fresh push
        applyStimulus("mid_push", 1'b1, 32'h77, 1'b0, 1'b0);
        midCycleReset("mid_rst");
        applyStimulus("post_rst", 1'b1, 32'h99, 1'b0, 1'b0);
        applyStimulus("post_rst2", 1'b0, 32'd0, 1'b1, 1'b0);

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            applyStimulus("rand", 1'($urandom_range(0, 1)), $urandom,
                          ($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule : tb_pipe_stage_reg
